// File: rtl/key_dispatch_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : key_dispatch_scheduler_if                                     |
// | Purpose  : Bundle between the key dispatch scheduler and the array of    |
// |            RC4 decoder cores.                                            |
// | Signals  : core_start       - one-hot start pulse, scheduler -> cores    |
// |            dispatch_key     - key for the core being started             |
// |            core_finish      - per-core end-of-run pulse, cores -> sched  |
// |            solution_correct - per-core result, valid with core_finish    |
// | Modports : master (scheduler side), slave (core array side)              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface key_dispatch_scheduler_if #(
  parameter int CORES             = 64,
  parameter int SECRET_KEY_LENGTH = 24
);
  logic [CORES-1:0]             core_start;
  logic [SECRET_KEY_LENGTH-1:0] dispatch_key;
  logic [CORES-1:0]             core_finish;
  logic [CORES-1:0]             solution_correct;

  modport master (
    output core_start,
    output dispatch_key,
    input  core_finish,
    input  solution_correct
  );

  modport slave (
    input  core_start,
    input  dispatch_key,
    output core_finish,
    output solution_correct
  );
endinterface
`default_nettype wire

// File: rtl/key_dispatch_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : key_dispatch_scheduler                                        |
// | Purpose  : Hands the next untried secret key to any idle decoder core,   |
// |            round-robin, stops on first solution / keyspace exhaustion /  |
// |            abort, drains in-flight cores and reports the winner.         |
// | Ports    : clk, reset (async, active-low)                                |
// |            start, abort      - one-cycle control pulses                  |
// |            core_bus (master) - core_start/dispatch_key out,              |
// |                                core_finish/solution_correct in           |
// |            next_key          - next undispatched key (L+1 bits)          |
// |            busy, done        - status levels                             |
// |            found, no_solution, winner_core, winner_key - result          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module key_dispatch_scheduler #(
  parameter int CORES             = 64,
  parameter int SECRET_KEY_LENGTH = 24,
  parameter int CORE_IDX_WIDTH    = 6
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            abort,
  key_dispatch_scheduler_if.master        core_bus,
  output logic [SECRET_KEY_LENGTH:0]      next_key,
  output logic                            busy,
  output logic                            done,
  output logic                            found,
  output logic                            no_solution,
  output logic [CORE_IDX_WIDTH-1:0]       winner_core,
  output logic [SECRET_KEY_LENGTH-1:0]    winner_key
);

  localparam int L     = SECRET_KEY_LENGTH;
  localparam int SUM_W = CORE_IDX_WIDTH + 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPATCH = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  // Counter value meaning "every key has been handed out" (2^L).
  localparam logic [L:0]                c_key_space = {1'b1, {L{1'b0}}};
  localparam logic [SUM_W-1:0]          c_cores_ext = SUM_W'(CORES);
  localparam logic [CORE_IDX_WIDTH-1:0] c_last_idx  = CORE_IDX_WIDTH'(CORES - 1);
  localparam logic [CORES-1:0]          c_one_hot0  = {{(CORES-1){1'b0}}, 1'b1};

  logic [1:0]                r_state;
  logic [1:0]                w_state_next;
  logic [L:0]                r_key_cnt;
  logic [CORES-1:0]          r_busy_mask;
  logic [CORE_IDX_WIDTH-1:0] r_ptr;
  logic                      r_found;
  logic                      r_no_solution;
  logic [CORE_IDX_WIDTH-1:0] r_winner_core;
  logic [L-1:0]              r_winner_key;
  logic [CORES-1:0]          r_core_start;
  logic [L-1:0]              r_dispatch_key;
  logic [L-1:0]              r_core_key [CORES];

  logic                      w_sel_valid;
  logic [CORE_IDX_WIDTH-1:0] w_sel_idx;
  logic [CORES-1:0]          w_sel_onehot;
  logic [CORE_IDX_WIDTH-1:0] w_ptr_next;
  logic [CORES-1:0]          w_hits;
  logic                      w_hit_any;
  logic [CORE_IDX_WIDTH-1:0] w_hit_idx;
  logic                      w_capture;
  logic                      w_exhausted;
  logic                      w_stop;
  logic                      w_dispatch_en;
  logic                      w_restart;
  logic                      w_drain_empty;

  // Round-robin pick: first core with a clear busy bit at or above the
  // pointer, wrapping. Scanning offsets from high to low lets the smallest
  // offset overwrite the result last.
  always_comb begin : p_select
    logic [SUM_W-1:0] w_cand;
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    w_cand      = '0;
    for (int i = CORES - 1; i >= 0; i--) begin
      w_cand = {1'b0, r_ptr} + SUM_W'(i);
      if (w_cand >= c_cores_ext) begin
        w_cand = w_cand - c_cores_ext;
      end
      if (!r_busy_mask[w_cand[CORE_IDX_WIDTH-1:0]]) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = w_cand[CORE_IDX_WIDTH-1:0];
      end
    end
  end

  assign w_sel_onehot = c_one_hot0 << w_sel_idx;
  assign w_ptr_next   = (w_sel_idx == c_last_idx) ? '0 : w_sel_idx + 1'b1;

  // Lowest-index correct finisher wins a simultaneous tie.
  always_comb begin : p_hit_encode
    w_hits    = core_bus.core_finish & core_bus.solution_correct;
    w_hit_any = |w_hits;
    w_hit_idx = '0;
    for (int i = CORES - 1; i >= 0; i--) begin
      if (w_hits[i]) begin
        w_hit_idx = CORE_IDX_WIDTH'(i);
      end
    end
  end

  assign w_exhausted   = (r_key_cnt == c_key_space);
  assign w_capture     = w_hit_any && !r_found &&
                         ((r_state == S_DISPATCH) || (r_state == S_DRAIN));
  assign w_stop        = w_capture || abort || w_exhausted;
  assign w_drain_empty = (r_busy_mask == '0);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (start)         w_state_next = S_DISPATCH;
      S_DISPATCH: if (w_stop)        w_state_next = S_DRAIN;
      S_DRAIN:    if (w_drain_empty) w_state_next = S_DONE;
      S_DONE:     if (start)         w_state_next = S_DISPATCH;
      default:                       w_state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // No dispatch in the cycle a stop condition is seen, so nothing new is
  // launched after a solution or abort has been sampled.
  always_comb begin
    busy          = (r_state == S_DISPATCH) || (r_state == S_DRAIN);
    done          = (r_state == S_DONE);
    w_restart     = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_dispatch_en = (r_state == S_DISPATCH) && !w_stop && w_sel_valid;
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_cnt      <= '0;
      r_busy_mask    <= '0;
      r_ptr          <= '0;
      r_found        <= 1'b0;
      r_no_solution  <= 1'b0;
      r_winner_core  <= '0;
      r_winner_key   <= '0;
      r_core_start   <= '0;
      r_dispatch_key <= '0;
      for (int i = 0; i < CORES; i++) begin
        r_core_key[i] <= '0;
      end
    end else begin
      r_core_start <= '0;
      if (w_restart) begin
        r_key_cnt     <= '0;
        r_busy_mask   <= '0;
        r_ptr         <= '0;
        r_found       <= 1'b0;
        r_no_solution <= 1'b0;
      end else begin
        // A finish frees its core one cycle later; a dispatch claims one.
        r_busy_mask <= (r_busy_mask & ~core_bus.core_finish) |
                       (w_dispatch_en ? w_sel_onehot : '0);
        if (w_dispatch_en) begin
          r_core_start          <= w_sel_onehot;
          r_dispatch_key        <= r_key_cnt[L-1:0];
          r_core_key[w_sel_idx] <= r_key_cnt[L-1:0];
          r_key_cnt             <= r_key_cnt + 1'b1;
          r_ptr                 <= w_ptr_next;
        end
        if (w_capture) begin
          r_found       <= 1'b1;
          r_winner_core <= w_hit_idx;
          r_winner_key  <= r_core_key[w_hit_idx];
        end
        if ((r_state == S_DRAIN) && w_drain_empty) begin
          r_no_solution <= w_exhausted && !r_found && !w_capture;
        end
      end
    end
  end

  assign core_bus.core_start   = r_core_start;
  assign core_bus.dispatch_key = r_dispatch_key;
  assign next_key              = r_key_cnt;
  assign found                 = r_found;
  assign no_solution           = r_no_solution;
  assign winner_core           = r_winner_core;
  assign winner_key            = r_winner_key;

endmodule
`default_nettype wire

// File: tb/tb_key_dispatch_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_key_dispatch_scheduler                                     |
// | Purpose  : Self-checking bench for key_dispatch_scheduler (4 cores,      |
// |            4-bit keys) with simulated cores and a behavioural model.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_key_dispatch_scheduler;

  localparam int CORES    = 4;
  localparam int L        = 4;
  localparam int IW       = 2;
  localparam int KEYSPACE = 16;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [L:0]    next_key;
  logic          busy, done, found, no_solution;
  logic [IW-1:0] winner_core;
  logic [L-1:0]  winner_key;

  key_dispatch_scheduler_if #(.CORES(CORES), .SECRET_KEY_LENGTH(L)) bus ();

  key_dispatch_scheduler #(
    .CORES(CORES), .SECRET_KEY_LENGTH(L), .CORE_IDX_WIDTH(IW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .core_bus(bus.master),
    .next_key(next_key), .busy(busy), .done(done), .found(found),
    .no_solution(no_solution), .winner_core(winner_core), .winner_key(winner_key)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- simulated cores ----------------
  int               run_len     = 0;   // 0: cores never finish by themselves
  int               jitter      = 0;
  int               correct_key = -1;
  logic [CORES-1:0] force_fin   = '0;
  logic [CORES-1:0] force_cor   = '0;

  initial begin : p_cores
    int rem [CORES];
    int key_of [CORES];
    logic [CORES-1:0] fin, cor, noise;
    for (int i = 0; i < CORES; i++) begin rem[i] = 0; key_of[i] = 0; end
    bus.core_finish      = '0;
    bus.solution_correct = '0;
    forever begin
      @(negedge clk);
      fin = '0;
      cor = '0;
      for (int i = 0; i < CORES; i++) begin
        if (!reset) rem[i] = 0;
        else begin
          if (rem[i] > 0) begin
            rem[i]--;
            if (rem[i] == 0) begin
              fin[i] = 1'b1;
              cor[i] = (key_of[i] == correct_key);
            end
          end
          if (bus.core_start[i]) begin
            key_of[i] = int'(bus.dispatch_key);
            rem[i] = (run_len == 0) ? 0 : run_len + int'($urandom_range(jitter, 0));
          end
        end
      end
      fin   = fin | force_fin;
      cor   = cor | force_cor;
      noise = CORES'($urandom);
      bus.core_finish      = fin;
      // Garbage on non-finishing bits: the result must only be used with finish.
      bus.solution_correct = (cor & fin) | (noise & ~fin);
    end
  end

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 dispatching, 2 draining, 3 done
  int phase = 0, cnt = 0, ptr = 0, m_found = 0, m_nosol = 0, m_wcore = 0, m_wkey = 0;
  int e_cs = -1, e_dkey = 0;
  int in_use [CORES];
  int key_held [CORES];

  initial begin : p_model
    int cap, pick, all_idle, stop;
    for (int i = 0; i < CORES; i++) begin in_use[i] = 0; key_held[i] = 0; end
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        phase = 0; cnt = 0; ptr = 0; m_found = 0; m_nosol = 0;
        m_wcore = 0; m_wkey = 0; e_cs = -1; e_dkey = 0;
        for (int i = 0; i < CORES; i++) begin in_use[i] = 0; key_held[i] = 0; end
      end else begin
        e_cs = -1;
        cap  = -1;
        if ((phase == 1 || phase == 2) && m_found == 0)
          for (int i = 0; i < CORES; i++)
            if (cap < 0 && bus.core_finish[i] && bus.solution_correct[i]) cap = i;
        all_idle = 1;
        for (int i = 0; i < CORES; i++) if (in_use[i] != 0) all_idle = 0;
        if ((phase == 0 || phase == 3) && start) begin
          phase = 1; cnt = 0; ptr = 0; m_found = 0; m_nosol = 0;
          for (int i = 0; i < CORES; i++) in_use[i] = 0;
        end else begin
          pick = -1;
          stop = (cap >= 0 || abort || cnt == KEYSPACE) ? 1 : 0;
          if (phase == 1 && stop == 0)
            for (int k = 0; k < CORES; k++)
              if (pick < 0 && in_use[(ptr + k) % CORES] == 0) pick = (ptr + k) % CORES;
          for (int i = 0; i < CORES; i++) if (bus.core_finish[i]) in_use[i] = 0;
          if (pick >= 0) begin
            in_use[pick] = 1; key_held[pick] = cnt;
            e_cs = pick; e_dkey = cnt;
            cnt++; ptr = (pick + 1) % CORES;
          end
          if (phase == 1 && stop != 0) phase = 2;
          else if (phase == 2 && all_idle != 0) begin
            phase   = 3;
            m_nosol = (cnt == KEYSPACE && m_found == 0 && cap < 0) ? 1 : 0;
          end
          if (cap >= 0) begin m_found = 1; m_wcore = cap; m_wkey = key_held[cap]; end
        end
      end
    end
  end

  // ---------------- compare against model ----------------
  initial begin : p_compare
    logic [CORES-1:0] ev;
    forever begin
      @(negedge clk);
      for (int i = 0; i < CORES; i++) ev[i] = (i == e_cs);
      check("core_start", 64'(bus.core_start), 64'(ev));
      if (e_cs >= 0) check("dispatch_key", 64'(bus.dispatch_key), 64'(e_dkey));
      check("next_key", 64'(next_key), 64'(cnt));
      check("busy", 64'(busy), 64'(phase == 1 || phase == 2));
      check("done", 64'(done), 64'(phase == 3));
      check("found", 64'(found), 64'(m_found));
      check("no_solution", 64'(no_solution), 64'(m_nosol));
      if (m_found != 0) begin
        check("winner_core", 64'(winner_core), 64'(m_wcore));
        check("winner_key", 64'(winner_key), 64'(m_wkey));
      end
    end
  end

  // ---------------- dispatch observer ----------------
  int pulses = 0;
  int seen [KEYSPACE];
  int core_of_key [KEYSPACE];

  initial begin : p_observe
    forever begin
      @(negedge clk);
      if (reset && bus.core_start != '0) begin
        pulses++;
        seen[int'(bus.dispatch_key)]++;
        for (int i = 0; i < CORES; i++)
          if (bus.core_start[i]) core_of_key[int'(bus.dispatch_key)] = i;
      end
    end
  end

  initial begin : p_watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask

  task automatic pulse_finish(input logic [CORES-1:0] f, input logic [CORES-1:0] c);
    @(posedge clk); #1; force_fin = f; force_cor = c;
    @(posedge clk); #1; force_fin = '0; force_cor = '0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    check(name, 64'(done), 64'd1);
  endtask

  task automatic clear_observer();
    for (int k = 0; k < KEYSPACE; k++) begin seen[k] = 0; core_of_key[k] = -1; end
    pulses = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_core_start"},  64'(bus.core_start), 64'd0);
    check({tag, "_dispatch_key"}, 64'(bus.dispatch_key), 64'd0);
    check({tag, "_next_key"},    64'(next_key), 64'd0);
    check({tag, "_busy"},        64'(busy), 64'd0);
    check({tag, "_done"},        64'(done), 64'd0);
    check({tag, "_found"},       64'(found), 64'd0);
    check({tag, "_no_solution"}, 64'(no_solution), 64'd0);
    check({tag, "_winner_core"}, 64'(winner_core), 64'd0);
    check({tag, "_winner_key"},  64'(winner_key), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : p_main
    int abort_at, n, snap;
    clear_observer();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    // Cores never finish: exactly four dispatches, keys 0..3 on cores 0..3.
    run_len = 0; correct_key = -1;
    pulse_start();
    check("t1_busy_after_start", 64'(busy), 64'd1);
    check("t1_no_pulse_yet", 64'(bus.core_start), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t1_core_start", 64'(bus.core_start), 64'(1 << k));
      check("t1_key", 64'(bus.dispatch_key), 64'(k));
    end
    repeat (5) begin
      @(negedge clk);
      check("t1_quiet", 64'(bus.core_start), 64'd0);
    end
    check("t1_busy_held", 64'(busy), 64'd1);
    check("t1_next_key", 64'(next_key), 64'd4);
    pulse_abort();
    pulse_finish(4'hF, 4'h0);
    wait_done("t1_done", 20);
    check("t1_found", 64'(found), 64'd0);
    check("t1_no_solution", 64'(no_solution), 64'd0);

    // Five-cycle runs, never correct: keyspace exhausts.
    clear_observer();
    run_len = 5; jitter = 0; correct_key = -1;
    pulse_start();
    wait_done("t2_done", 300);
    check("t2_no_solution", 64'(no_solution), 64'd1);
    check("t2_found", 64'(found), 64'd0);
    check("t2_next_key", 64'(next_key), 64'd16);
    for (int k = 0; k < KEYSPACE; k++) check("t2_key_once", 64'(seen[k]), 64'd1);
    check("t2_wrap_key4_core", 64'(core_of_key[4]), 64'd0);
    check("t2_key6_core", 64'(core_of_key[6]), 64'd2);

    // Key 6 is the secret: core 2 solves it, dispatching stops after key 8.
    clear_observer();
    correct_key = 6;
    pulse_start();
    wait_done("t3_done", 300);
    check("t3_found", 64'(found), 64'd1);
    check("t3_winner_core", 64'(winner_core), 64'd2);
    check("t3_winner_key", 64'(winner_key), 64'd6);
    check("t3_no_solution", 64'(no_solution), 64'd0);
    check("t3_next_key", 64'(next_key), 64'd9);

    // Cores 1 and 3 correct together; a later correct from core 0 is ignored.
    run_len = 0; correct_key = -1;
    pulse_start();
    repeat (6) @(negedge clk);
    pulse_finish(4'b1010, 4'b1010);
    pulse_finish(4'b0001, 4'b0001);
    pulse_finish(4'b0100, 4'b0000);
    wait_done("t4_done", 20);
    check("t4_found", 64'(found), 64'd1);
    check("t4_winner_core", 64'(winner_core), 64'd1);
    check("t4_winner_key", 64'(winner_key), 64'd1);

    // Abort mid-dispatch with running cores, then restart from key 0.
    run_len = 4; jitter = 2; correct_key = -1;
    pulse_start();
    repeat (int'($urandom_range(14, 8))) @(negedge clk);
    pulse_abort();
    snap = pulses;
    wait_done("t5_done", 50);
    check("t5_no_new_starts", 64'(pulses), 64'(snap));
    check("t5_found", 64'(found), 64'd0);
    check("t5_no_solution", 64'(no_solution), 64'd0);
    pulse_start();
    @(negedge clk);
    check("t5_restart_core", 64'(bus.core_start), 64'd1);
    check("t5_restart_key", 64'(bus.dispatch_key), 64'd0);
    wait_done("t5_second_done", 300);

    // Reset asserted during DRAIN: outputs clear immediately.
    run_len = 0;
    pulse_start();
    repeat (6) @(negedge clk);
    pulse_abort();
    check("t6_in_drain", 64'(busy), 64'd1);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    check_all_zero("t6_async");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pulse_start();
    @(negedge clk);
    check("t6_first_core", 64'(bus.core_start), 64'd1);
    check("t6_first_key", 64'(bus.dispatch_key), 64'd0);
    @(negedge clk);
    pulse_abort();
    pulse_finish(4'hF, 4'h0);
    wait_done("t6_done", 20);

    // Randomised runs against the model.
    for (int r = 0; r < 8; r++) begin
      run_len     = int'($urandom_range(6, 1));
      jitter      = int'($urandom_range(3, 0));
      correct_key = ($urandom_range(3, 0) == 0) ? -1 : int'($urandom_range(15, 0));
      abort_at    = ($urandom_range(2, 0) == 0) ? int'($urandom_range(40, 3)) : -1;
      pulse_start();
      n = 0;
      while (!done && n < 400) begin
        @(negedge clk);
        abort = (n == abort_at);
        n++;
      end
      abort = 1'b0;
      check("rand_done", 64'(done), 64'd1);
      if (abort_at < 0 && correct_key >= 0) begin
        check("rand_found", 64'(found), 64'd1);
        check("rand_winner_key", 64'(winner_key), 64'(correct_key));
      end
      repeat (2) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_dispatch_scheduler.md
# key_dispatch_scheduler

Dynamic work scheduler for the multi-core RC4 decoder. Replaces lockstep start-all sequencing: it hands the next untried secret key to any idle core as soon as that core finishes, round-robin. It stops dispatching on the first correct solution, on keyspace exhaustion, or on abort. It then drains in-flight cores and reports the winning core index and key to the top-level state machine and HEX display.

## Interface
Parameters:
- cores, 64, number of decoder cores
- secret_key_length, 24, key width L in bits
- core_idx_width, 6, width of core index; must satisfy 2^core_idx_width >= cores

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a search from key 0; ignored unless state is IDLE or DONE
- abort  in  1  one-cycle pulse; stops dispatching; ignored in IDLE and DONE
- core_finish  in  cores  per-core one-cycle pulse at end of a core run
- solution_correct  in  cores  per-core result; sampled only in the cycle the matching core_finish bit is high
- core_start  out  cores  registered one-hot pulse; at most one bit high per cycle
- dispatch_key  out  L  key for the core being started; valid while core_start is nonzero
- next_key  out  L+1  next undispatched key, for the display
- busy  out  1  high in DISPATCH and DRAIN
- done  out  1  level; high in DONE until the next accepted start
- found  out  1  valid with done; a solution was captured
- no_solution  out  1  valid with done; keyspace exhausted and no solution found
- winner_core  out  core_idx_width  index of the solving core; valid when found=1
- winner_key  out  L  key that solved; valid when found=1

## Operation
- States: IDLE, DISPATCH, DRAIN, DONE.
- IDLE → DISPATCH on start. On that transition: key counter := 0, busy mask := 0, pointer := 0, found := 0, no_solution := 0.
- DISPATCH, each cycle:
  - Select the first core whose busy-mask bit is clear, searching upward from the pointer and wrapping modulo cores.
  - If a core is selected and key counter < 2^L: next cycle, pulse core_start for that core with dispatch_key = counter[L-1:0]. Also set its busy bit, store the key in that core's key register, increment the counter, and set pointer := selected+1 mod cores.
- Finish handling, all non-IDLE states: a core_finish bit clears that core's busy bit one cycle later. That core is therefore not eligible in the cycle its finish is seen; it is eligible from the next cycle.
- Solution capture: if a core_finish bit has solution_correct set and found=0, latch found := 1, winner_core, and winner_key (from the core's key register).
  - Simultaneous solutions: the lowest index wins.
  - Solutions arriving after the first capture are ignored.
- DISPATCH → DRAIN when any of the following holds: a solution is captured, abort is sampled, or key counter reaches 2^L (the counter is L+1 bits wide and never wraps).
- DRAIN issues no core_start and waits for the busy mask to be all-zero; a solution can still be captured during drain. DRAIN → DONE when the busy mask is zero.
- Entering DONE: no_solution := (counter == 2^L) && !found. Abort with no capture gives found=0 and no_solution=0.
- DONE → DISPATCH on start, with the same reinitialisation as from IDLE.
- Reset, mid-operation or otherwise: immediate return to IDLE with every register cleared.

## Timing
- Reset values: core_start=0, dispatch_key=0, next_key=0, busy=0, done=0, found=0, no_solution=0, winner_core=0, winner_key=0.
- start sampled at edge n: busy=1 after edge n; first core_start is high in the cycle after edge n+1.
- Steady state: one dispatch per cycle while idle cores exist. A core that finishes at cycle t can be restarted no earlier than t+2.
- done rises one cycle after the busy mask becomes empty in DRAIN.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- cores=4, L=4, cores never finish: start → core_start for cores 0,1,2,3 with keys 0,1,2,3 on consecutive cycles, then no further pulses, busy=1.
- cores=4, L=4, each core finishes 5 cycles after its start, never correct: all 16 keys dispatched exactly once, the pointer wraps, then done=1, no_solution=1, found=0.
- Same setup, core 2 reports correct on its run for key 6: dispatching stops, in-flight cores drain, then done=1, found=1, winner_core=2, winner_key=6, no_solution=0.
- Cores 1 and 3 report correct in the same cycle: winner_core=1; a later correct from core 0 is ignored.
- abort mid-DISPATCH: no further core_start; done=1 after drain, with found=0 and no_solution=0. Then start: keys restart at 0.
- reset low during DRAIN: all outputs are 0 immediately; start after release begins at key 0 with core 0.
